rs485_txn_ctrl: RTL and testbench

//  Transaction controller placed directly upstream of the RS-485 PHY master, which serialises bytes and reports status.

---
 rtl/rs485_txn_ctrl_if.sv | 46 ++++
 rtl/rs485_txn_ctrl.sv | 306 ++++++++++++++++++++++++++++++
 tb/tb_rs485_txn_ctrl.sv | 360 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rs485_txn_ctrl_if.sv
// ----------------------------------------------------------------------------
// rs485_txn_ctrl_if
// Byte-level link between the transaction controller and the RS-485 PHY
// master. The controller offers request bytes one at a time and the PHY
// hands back received ACK bytes plus a sticky frame status.
//
// Signals
//   txd_rdy  controller -> PHY  byte on txd valid, more bytes follow
//   txd      controller -> PHY  current tx byte, stable until txd_rd
//   txd_rd   PHY -> controller  1-clk pulse, current tx byte consumed
//   rxd      PHY -> controller  received byte
//   rxd_wr   PHY -> controller  1-clk pulse, rxd valid
//   status   PHY -> controller  0 busy/idle, 1 RX_OK, 2 RX_ERR; held until next TX
//
// Modports
//   master   the transaction controller side
//   slave    the PHY master side
// ----------------------------------------------------------------------------
interface rs485_txn_ctrl_if;

    logic       txd_rdy;
    logic [7:0] txd;
    logic       txd_rd;
    logic [7:0] rxd;
    logic       rxd_wr;
    logic [2:0] status;

    modport master (
        output txd_rdy,
        output txd,
        input  txd_rd,
        input  rxd,
        input  rxd_wr,
        input  status
    );

    modport slave (
        input  txd_rdy,
        input  txd,
        output txd_rd,
        output rxd,
        output rxd_wr,
        output status
    );

endinterface

// File: rtl/rs485_txn_ctrl.sv
// ----------------------------------------------------------------------------
// rs485_txn_ctrl
// Transaction controller sitting directly upstream of the RS-485 PHY master.
// Each accepted host start builds a request frame (DEV_ADR, DEV_CMD, then
// 0..MAX_DATA data bytes from the tx buffer), feeds it to the PHY byte by
// byte, then collects the ACK frame, checks the ADR/CMD echo, stores the
// ACK payload in the rx buffer and reports a 3-bit result with a done pulse.
// A response timeout bounds the wait for the PHY status.
//
// Ports
//   p_in_clk, p_in_rst         clock, asynchronous active-high reset
//   p_in_start                 1-clk start pulse, ignored while busy
//   p_in_adr/p_in_cmd/p_in_len frame header and tx data count, sampled on start
//   p_in_txbuf_wr/_a/_d        tx buffer write port, ignored while busy
//   p_in_rxbuf_a/p_out_rxbuf_q rx buffer read port, 1-clk registered latency
//   p_out_rx_len               stored ACK data byte count
//   p_out_busy                 accepted start .. done cycle inclusive
//   p_out_done                 1-clk pulse, p_out_result valid
//   p_out_result               0 OK,1 TIMEOUT,2 PHY_ERR,3 SHORT,4 ADR_MIS,5 CMD_MIS,6 OVERFLOW
//   phy                        byte link to the PHY master (master modport)
// ----------------------------------------------------------------------------
module rs485_txn_ctrl #(
    parameter int MAX_DATA   = 8,
    parameter int TMO_CYCLES = 128000
) (
    input  logic                        p_in_clk,
    input  logic                        p_in_rst,

    input  logic                        p_in_start,
    input  logic [7:0]                  p_in_adr,
    input  logic [7:0]                  p_in_cmd,
    input  logic [3:0]                  p_in_len,

    input  logic                        p_in_txbuf_wr,
    input  logic [$clog2(MAX_DATA)-1:0] p_in_txbuf_a,
    input  logic [7:0]                  p_in_txbuf_d,

    input  logic [$clog2(MAX_DATA)-1:0] p_in_rxbuf_a,
    output logic [7:0]                  p_out_rxbuf_q,
    output logic [3:0]                  p_out_rx_len,

    output logic                        p_out_busy,
    output logic                        p_out_done,
    output logic [2:0]                  p_out_result,

    rs485_txn_ctrl_if.master            phy
);

    localparam int AW = $clog2(MAX_DATA);
    localparam int TW = (TMO_CYCLES > 1) ? $clog2(TMO_CYCLES) : 1;

    localparam logic [3:0]    MAX_LEN  = 4'(MAX_DATA);
    // ACK byte index limit: bytes 2 .. MAX_DATA+1 land in the rx buffer
    localparam logic [4:0]    RX_LIMIT = 5'(MAX_DATA + 2);
    localparam logic [TW-1:0] TMO_LAST = TW'(TMO_CYCLES - 1);

    localparam logic [2:0] RES_OK       = 3'd0;
    localparam logic [2:0] RES_TIMEOUT  = 3'd1;
    localparam logic [2:0] RES_PHY_ERR  = 3'd2;
    localparam logic [2:0] RES_SHORT    = 3'd3;
    localparam logic [2:0] RES_ADR_MIS  = 3'd4;
    localparam logic [2:0] RES_CMD_MIS  = 3'd5;
    localparam logic [2:0] RES_OVERFLOW = 3'd6;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_TX,
        ST_WAIT_RSP,
        ST_DONE
    } state_t;

    state_t state;
    state_t state_n;

    // transaction context latched on start
    logic [7:0]    adr_q;
    logic [7:0]    cmd_q;
    logic [3:0]    len_q;
    logic [3:0]    idx;
    logic [3:0]    rx_cnt;
    logic          adr_mis;
    logic          cmd_mis;
    logic          ovf;
    logic [TW-1:0] tmo;

    logic [7:0] txbuf [MAX_DATA];
    logic [7:0] rxbuf [MAX_DATA];

    logic       busy;
    logic       done;
    logic       txd_rdy;
    logic [7:0] txd;
    logic [7:0] rxbuf_q;
    logic [2:0] result;
    logic [3:0] rx_len;

    // control strobes from the FSM decode
    logic accept;
    logic tx_rd;
    logic tx_last;
    logic rx_take;
    logic tmo_hit;

    // response-check next values
    logic          adr_mis_n;
    logic          cmd_mis_n;
    logic          ovf_n;
    logic [3:0]    rx_cnt_n;
    logic          rx_store;
    logic [AW-1:0] rx_wa;
    logic [2:0]    result_n;
    logic [3:0]    rx_len_n;
    logic [3:0]    data_cnt;
    logic [7:0]    tx_next;

    assign p_out_rxbuf_q = rxbuf_q;
    assign p_out_rx_len  = rx_len;
    assign p_out_busy    = busy;
    assign p_out_done    = done;
    assign p_out_result  = result;
    assign phy.txd_rdy   = txd_rdy;
    assign phy.txd       = txd;

    // Byte that follows the one just consumed: cmd after adr, then the
    // tx buffer in order (frame byte idx+1 is txbuf[idx-1]).
    assign tx_rd   = (state == ST_TX) && phy.txd_rd;
    assign tx_next = (idx == 4'd0) ? cmd_q : txbuf[AW'(idx - 4'd1)];
    assign rx_wa   = AW'(rx_cnt - 4'd2);

    // State register.
    always_ff @(posedge p_in_clk or posedge p_in_rst) begin
        if (p_in_rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state decode. Status and rx bytes are only looked at while
    // waiting for the response; a non-zero status takes precedence over
    // the timeout in the same cycle.
    always_comb begin
        state_n = state;
        accept  = 1'b0;
        tx_last = 1'b0;
        rx_take = 1'b0;
        tmo_hit = 1'b0;
        case (state)
            ST_IDLE: begin
                if (p_in_start) begin
                    accept  = 1'b1;
                    state_n = ST_TX;
                end
            end
            ST_TX: begin
                if (phy.txd_rd && (idx == len_q + 4'd1)) begin
                    tx_last = 1'b1;
                    state_n = ST_WAIT_RSP;
                end
            end
            ST_WAIT_RSP: begin
                rx_take = phy.rxd_wr;
                if (phy.status != 3'd0) begin
                    state_n = ST_DONE;
                end else if (tmo == TMO_LAST) begin
                    tmo_hit = 1'b1;
                    state_n = ST_DONE;
                end
            end
            ST_DONE: begin
                state_n = ST_IDLE;
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    // ACK byte classification and result selection. The result is built
    // from the flag values that include a byte arriving in the same cycle
    // as the status, so that byte is always accounted for.
    always_comb begin
        adr_mis_n = adr_mis;
        cmd_mis_n = cmd_mis;
        ovf_n     = ovf;
        rx_cnt_n  = rx_cnt;
        rx_store  = 1'b0;
        if (rx_take) begin
            if (rx_cnt == 4'd0) begin
                adr_mis_n = (phy.rxd != adr_q);
            end else if (rx_cnt == 4'd1) begin
                cmd_mis_n = (phy.rxd != cmd_q);
            end else if ({1'b0, rx_cnt} < RX_LIMIT) begin
                rx_store = 1'b1;
            end else begin
                ovf_n = 1'b1;
            end
            if (rx_cnt != 4'd15) begin
                rx_cnt_n = rx_cnt + 4'd1;
            end
        end

        if (tmo_hit) begin
            result_n = RES_TIMEOUT;
        end else if (phy.status == 3'd2) begin
            result_n = RES_PHY_ERR;
        end else if (rx_cnt_n < 4'd2) begin
            result_n = RES_SHORT;
        end else if (adr_mis_n) begin
            result_n = RES_ADR_MIS;
        end else if (cmd_mis_n) begin
            result_n = RES_CMD_MIS;
        end else if (ovf_n) begin
            result_n = RES_OVERFLOW;
        end else begin
            result_n = RES_OK;
        end

        data_cnt = rx_cnt_n - 4'd2;
        if (rx_cnt_n < 4'd2) begin
            rx_len_n = 4'd0;
        end else if (data_cnt > MAX_LEN) begin
            rx_len_n = MAX_LEN;
        end else begin
            rx_len_n = data_cnt;
        end
    end

    // Transaction datapath and registered outputs. Reset drops everything
    // at once, including a transaction in flight, without a done pulse.
    always_ff @(posedge p_in_clk or posedge p_in_rst) begin
        if (p_in_rst) begin
            adr_q   <= 8'd0;
            cmd_q   <= 8'd0;
            len_q   <= 4'd0;
            idx     <= 4'd0;
            rx_cnt  <= 4'd0;
            adr_mis <= 1'b0;
            cmd_mis <= 1'b0;
            ovf     <= 1'b0;
            tmo     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            txd_rdy <= 1'b0;
            txd     <= 8'd0;
            result  <= 3'd0;
            rx_len  <= 4'd0;
        end else begin
            done <= (state == ST_WAIT_RSP) && (state_n == ST_DONE);

            if (accept) begin
                adr_q   <= p_in_adr;
                cmd_q   <= p_in_cmd;
                len_q   <= (p_in_len > MAX_LEN) ? MAX_LEN : p_in_len;
                idx     <= 4'd0;
                rx_cnt  <= 4'd0;
                adr_mis <= 1'b0;
                cmd_mis <= 1'b0;
                ovf     <= 1'b0;
                tmo     <= '0;
                busy    <= 1'b1;
                txd_rdy <= 1'b1;
                txd     <= p_in_adr;
                result  <= 3'd0;
                rx_len  <= 4'd0;
            end

            if (tx_rd) begin
                idx <= idx + 4'd1;
                if (tx_last) begin
                    txd_rdy <= 1'b0;
                end else begin
                    txd <= tx_next;
                end
            end

            if (state == ST_WAIT_RSP) begin
                tmo     <= tmo + TW'(1);
                rx_cnt  <= rx_cnt_n;
                adr_mis <= adr_mis_n;
                cmd_mis <= cmd_mis_n;
                ovf     <= ovf_n;
                if (state_n == ST_DONE) begin
                    result <= result_n;
                    rx_len <= rx_len_n;
                end
            end

            if (state == ST_DONE) begin
                busy <= 1'b0;
            end
        end
    end

    // Buffer storage has no reset; contents are meaningless until written.
    always_ff @(posedge p_in_clk) begin
        if (p_in_txbuf_wr && !busy) begin
            txbuf[p_in_txbuf_a] <= p_in_txbuf_d;
        end
        if (rx_store) begin
            rxbuf[rx_wa] <= phy.rxd;
        end
        rxbuf_q <= rxbuf[p_in_rxbuf_a];
    end

endmodule

// File: tb/tb_rs485_txn_ctrl.sv
// ----------------------------------------------------------------------------
// tb_rs485_txn_ctrl
// Self-checking bench for rs485_txn_ctrl. Stimulus tasks play the host and
// the PHY master; expected frame bytes, done results and rx buffer reads are
// queued when issued and a negedge monitor pops and compares them whenever
// the DUT presents the matching output. The timeout is shortened so the
// timeout case stays quick.
// ----------------------------------------------------------------------------
module tb_rs485_txn_ctrl;

    localparam int MAX_DATA = 8;
    localparam int TMO      = 200;
    localparam int AW       = $clog2(MAX_DATA);

    typedef struct packed {
        logic [2:0] res;
        logic [3:0] len;
    } done_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [7:0]    adr;
    logic [7:0]    cmd;
    logic [3:0]    len;
    logic          txbuf_wr;
    logic [AW-1:0] txbuf_a;
    logic [7:0]    txbuf_d;
    logic [AW-1:0] rxbuf_a;
    logic [7:0]    rxbuf_q;
    logic [3:0]    rx_len;
    logic          busy;
    logic          done;
    logic [2:0]    result;

    rs485_txn_ctrl_if phy_bus ();

    rs485_txn_ctrl #(
        .MAX_DATA   (MAX_DATA),
        .TMO_CYCLES (TMO)
    ) dut (
        .p_in_clk      (clk),
        .p_in_rst      (rst),
        .p_in_start    (start),
        .p_in_adr      (adr),
        .p_in_cmd      (cmd),
        .p_in_len      (len),
        .p_in_txbuf_wr (txbuf_wr),
        .p_in_txbuf_a  (txbuf_a),
        .p_in_txbuf_d  (txbuf_d),
        .p_in_rxbuf_a  (rxbuf_a),
        .p_out_rxbuf_q (rxbuf_q),
        .p_out_rx_len  (rx_len),
        .p_out_busy    (busy),
        .p_out_done    (done),
        .p_out_result  (result),
        .phy           (phy_bus)
    );

    always #4 clk = ~clk;

    int errors      = 0;
    int checks      = 0;
    int cyc         = 0;
    int done_seen   = 0;
    int done_expect = 0;
    int done_cyc    = 0;
    int wait_entry  = 0;

    logic [7:0] tb_txbuf [MAX_DATA];
    logic [7:0] exp_txd [$];
    done_t      exp_done [$];
    logic [7:0] exp_rx [$];
    logic [7:0] rsp_bytes [$];
    logic       rd_req = 1'b0;
    logic       rd_d   = 1'b0;

    always @(posedge clk) begin
        cyc  <= cyc + 1;
        rd_d <= rd_req;
    end

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic report_fail(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        errors++;
        $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Monitor: compares each presented output against the head of its queue.
    always @(negedge clk) begin
        if (!rst) begin
            if (phy_bus.txd_rd && phy_bus.txd_rdy) begin
                if (exp_txd.size() == 0) report_fail("txd_unexpected", phy_bus.txd, 0);
                else check_output("txd", phy_bus.txd, exp_txd.pop_front());
            end
            if (done) begin
                done_seen++;
                done_cyc = cyc;
                check_output("busy_at_done", busy, 1);
                if (exp_done.size() == 0) begin
                    report_fail("done_unexpected", result, 0);
                end else begin
                    done_t e;
                    e = exp_done.pop_front();
                    check_output("result", result, e.res);
                    check_output("rx_len", rx_len, e.len);
                end
            end
            if (rd_d) begin
                if (exp_rx.size() == 0) report_fail("rxbuf_unexpected", rxbuf_q, 0);
                else check_output("rxbuf_q", rxbuf_q, exp_rx.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_tx(input int a, input logic [7:0] d);
        txbuf_a  = AW'(a);
        txbuf_d  = d;
        txbuf_wr = 1'b1;
        tick();
        txbuf_wr = 1'b0;
        tb_txbuf[a] = d;
    endtask

    task automatic expect_done(input logic [2:0] res, input logic [3:0] l);
        done_t e;
        e.res = res;
        e.len = l;
        exp_done.push_back(e);
        done_expect++;
    endtask

    // Host start; the PHY clears its status on entering TX.
    task automatic apply_stimulus(input logic [7:0] a, input logic [7:0] c, input logic [3:0] l);
        int n;
        n = (l > MAX_DATA) ? MAX_DATA : int'(l);
        exp_txd.push_back(a);
        exp_txd.push_back(c);
        for (int i = 0; i < n; i++) exp_txd.push_back(tb_txbuf[i]);
        phy_bus.status = 3'd0;
        adr   = a;
        cmd   = c;
        len   = l;
        start = 1'b1;
        tick();
        start = 1'b0;
        check_output("busy_after_start", busy, 1);
        check_output("txd_rdy_after_start", phy_bus.txd_rdy, 1);
    endtask

    // PHY model: consume bytes with one idle cycle between reads.
    task automatic phy_read_frame(input int n_exp);
        int n = 0;
        for (int g = 0; g < 40; g++) begin
            if (!phy_bus.txd_rdy) break;
            tick();
            phy_bus.txd_rd = 1'b1;
            tick();
            phy_bus.txd_rd = 1'b0;
            n++;
            wait_entry = cyc;
            if (phy_bus.txd_rdy && exp_txd.size() > 0)
                check_output("txd_next_latency", phy_bus.txd, exp_txd[0]);
        end
        check_output("frame_bytes", n, n_exp);
        check_output("txd_rdy_after_frame", phy_bus.txd_rdy, 0);
    endtask

    task automatic phy_send(input logic [7:0] b);
        phy_bus.rxd    = b;
        phy_bus.rxd_wr = 1'b1;
        tick();
        phy_bus.rxd_wr = 1'b0;
    endtask

    task automatic phy_status(input logic [2:0] s);
        phy_bus.status = s;
        tick();
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (done_seen < done_expect && n < budget) begin
            tick();
            n++;
        end
        if (done_seen < done_expect) begin
            report_fail("done_wait_expired", done_seen, done_expect);
        end else begin
            check_output("busy_after_done", busy, 0);
            repeat (3) tick();
            check_output("done_pulse_count", done_seen, done_expect);
        end
    endtask

    task automatic read_rx(input int a, input logic [7:0] e);
        rxbuf_a = AW'(a);
        rd_req  = 1'b1;
        exp_rx.push_back(e);
        tick();
        rd_req = 1'b0;
        tick();
    endtask

    task automatic run_t1();
        write_tx(0, 8'hA5);
        write_tx(1, 8'h3C);
        expect_done(3'd0, 4'd1);
        apply_stimulus(8'h15, 8'h02, 4'd2);
        phy_read_frame(4);
        phy_send(8'h15);
        phy_send(8'h02);
        // last byte and RX_OK in the same clock
        phy_bus.rxd    = 8'h77;
        phy_bus.rxd_wr = 1'b1;
        phy_bus.status = 3'd1;
        tick();
        phy_bus.rxd_wr = 1'b0;
        check_output("done_latency", done, 1);
        wait_done(10);
        read_rx(0, 8'h77);
    endtask

    task automatic run_rsp(input logic [3:0] l, input int n_frame, input logic [2:0] st,
                           input logic [2:0] res, input logic [3:0] rl);
        expect_done(res, rl);
        apply_stimulus(8'h15, 8'h02, l);
        phy_read_frame(n_frame);
        foreach (rsp_bytes[i]) phy_send(rsp_bytes[i]);
        phy_status(st);
        wait_done(10);
    endtask

    task automatic reset_pulse(input string tag);
        rst = 1'b1;
        #1;
        check_output({tag, "_txd_rdy"}, phy_bus.txd_rdy, 0);
        check_output({tag, "_busy"}, busy, 0);
        phy_bus.txd_rd = 1'b0;
        phy_bus.rxd_wr = 1'b0;
        tick();
        rst = 1'b0;
        exp_txd.delete();
        repeat (3) tick();
        check_output({tag, "_no_done"}, done_seen, done_expect);
    endtask

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst            = 1'b1;
        start          = 1'b0;
        adr            = 8'd0;
        cmd            = 8'd0;
        len            = 4'd0;
        txbuf_wr       = 1'b0;
        txbuf_a        = '0;
        txbuf_d        = 8'd0;
        rxbuf_a        = '0;
        phy_bus.txd_rd = 1'b0;
        phy_bus.rxd    = 8'd0;
        phy_bus.rxd_wr = 1'b0;
        phy_bus.status = 3'd0;
        for (int i = 0; i < MAX_DATA; i++) tb_txbuf[i] = 8'd0;

        repeat (3) tick();
        check_output("rst_busy", busy, 0);
        check_output("rst_done", done, 0);
        check_output("rst_txd_rdy", phy_bus.txd_rdy, 0);
        check_output("rst_txd", phy_bus.txd, 0);
        check_output("rst_result", result, 0);
        check_output("rst_rx_len", rx_len, 0);
        rst = 1'b0;
        tick();

        $display("[TB] T1 basic transaction");
        run_t1();

        $display("[TB] T2 response timeout");
        expect_done(3'd1, 4'd0);
        apply_stimulus(8'h15, 8'h02, 4'd0);
        phy_read_frame(2);
        wait_done(TMO + 20);
        check_output("timeout_latency", done_cyc - wait_entry, TMO);

        $display("[TB] T3 error results");
        rsp_bytes = {8'h15, 8'h02};
        run_rsp(4'd0, 2, 3'd2, 3'd2, 4'd0);
        rsp_bytes = {8'h16, 8'h02};
        run_rsp(4'd1, 3, 3'd1, 3'd4, 4'd0);
        rsp_bytes = {8'h15, 8'h03};
        run_rsp(4'd0, 2, 3'd1, 3'd5, 4'd0);
        rsp_bytes = {8'h15};
        run_rsp(4'd0, 2, 3'd1, 3'd3, 4'd0);

        $display("[TB] T4 overflow and length clamp");
        for (int i = 0; i < MAX_DATA; i++) write_tx(i, 8'h80 + 8'(i));
        rsp_bytes = {8'h15, 8'h02};
        for (int i = 0; i < 10; i++) rsp_bytes.push_back(8'h40 + 8'(i));
        run_rsp(4'd12, 10, 3'd1, 3'd6, 4'd8);
        read_rx(7, 8'h47);
        read_rx(0, 8'h40);

        $display("[TB] T5 start and txbuf write while busy");
        expect_done(3'd0, 4'd0);
        apply_stimulus(8'h15, 8'h02, 4'd2);
        txbuf_a  = '0;
        txbuf_d  = 8'hEE;
        txbuf_wr = 1'b1;
        tick();
        txbuf_wr = 1'b0;
        adr   = 8'h99;
        len   = 4'd5;
        start = 1'b1;
        tick();
        start = 1'b0;
        phy_read_frame(4);
        start = 1'b1;
        tick();
        start = 1'b0;
        phy_send(8'h15);
        phy_send(8'h02);
        phy_status(3'd1);
        wait_done(10);

        $display("[TB] T6 reset mid-transaction");
        apply_stimulus(8'h15, 8'h02, 4'd2);
        tick();
        phy_bus.txd_rd = 1'b1;
        tick();
        phy_bus.txd_rd = 1'b0;
        reset_pulse("rst_in_tx");
        apply_stimulus(8'h15, 8'h02, 4'd0);
        phy_read_frame(2);
        phy_send(8'h15);
        reset_pulse("rst_in_wait");
        run_t1();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
